// File: rtl/vga_timing_pkg.sv
// Default 800x600@60 (40 MHz) raster timing shared by the timing generator and the draw/sync stages.
package vga_timing_pkg;

    localparam int CNT_W    = 11;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b1;

    // Half-open window test [lo, hi) used for the sync pulse decode.
    function automatic logic in_range(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster bus between the timing generator and the downstream background/draw/sync stages.
interface vga_if;
    import vga_timing_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [11:0]      rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter; wrap flags the enabled edge on which cnt returns to zero.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = 1055,
    parameter int W   = CNT_W
) (
    input  logic         clk40MHz,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign wrap = inc && (cnt == MAX_V);

    always_ff @(posedge clk40MHz) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered blanking, sync and start strobes
// that always describe the pixel currently shown on hcount/vcount.
module vga_timing_gen #(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic HS_POL   = vga_timing_pkg::HS_POL,
    parameter logic VS_POL   = vga_timing_pkg::VS_POL
) (
    input  logic clk40MHz,
    input  logic rst,
    input  logic en,
    vga_if.out   tim_if,
    output logic line_start,
    output logic frame_start
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_V    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_V = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_V   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_V    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START_V = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_V   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
        end
    endgenerate

    logic [CNT_W-1:0] hcnt, vcnt;
    logic [CNT_W-1:0] h_next, v_next;
    logic             h_wrap, v_wrap, v_inc;
    logic             hsync, vsync, hblnk, vblnk;

    assign v_inc = en & h_wrap;

    mod_counter #(.MAX(H_TOTAL - 1), .W(CNT_W)) u_hcnt (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .inc      (en),
        .cnt      (hcnt),
        .wrap     (h_wrap)
    );

    mod_counter #(.MAX(V_TOTAL - 1), .W(CNT_W)) u_vcnt (
        .clk40MHz (clk40MHz),
        .rst      (rst),
        .inc      (v_inc),
        .cnt      (vcnt),
        .wrap     (v_wrap)
    );

    // Look-ahead of the counters so the decode registers land in the same cycle as the counts.
    always_comb begin
        h_next = h_wrap ? '0 : hcnt + CNT_W'(1);
        v_next = vcnt;
        if (v_wrap) begin
            v_next = '0;
        end else if (h_wrap) begin
            v_next = vcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk40MHz) begin
        if (!rst) begin
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else if (en) begin
            hblnk       <= (h_next >= H_ACT_V);
            vblnk       <= (v_next >= V_ACT_V);
            hsync       <= in_range(h_next, HS_START_V, HS_END_V) ? HS_POL : ~HS_POL;
            vsync       <= in_range(v_next, VS_START_V, VS_END_V) ? VS_POL : ~VS_POL;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    assign tim_if.hcount = hcnt;
    assign tim_if.vcount = vcnt;
    assign tim_if.hsync  = hsync;
    assign tim_if.vsync  = vsync;
    assign tim_if.hblnk  = hblnk;
    assign tim_if.vblnk  = vblnk;
    assign tim_if.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line-level vectors, shrunken active-low instance for frame-level behaviour.
module tb_vga_timing_gen;

    logic clk40MHz = 1'b0;
    always #5 clk40MHz = ~clk40MHz;

    logic rstA = 1'b0, enA = 1'b1, lsA, fsA;
    logic rstB = 1'b0, enB = 1'b1, lsB, fsB;

    vga_if ifA();
    vga_if ifB();

    vga_timing_gen dutA (
        .clk40MHz    (clk40MHz),
        .rst         (rstA),
        .en          (enA),
        .tim_if      (ifA),
        .line_start  (lsA),
        .frame_start (fsA)
    );

    // 25 x 18 raster, sync on h 18..21 and v 13..14, both active low.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dutB (
        .clk40MHz    (clk40MHz),
        .rst         (rstB),
        .en          (enB),
        .tim_if      (ifB),
        .line_start  (lsB),
        .frame_start (fsB)
    );

    typedef struct {
        string name;
        logic  rst;
        logic  en;
        int    cycles;
        int    h;
        int    v;
        logic  hs, vs, hb, vb, ls, fs;
    } vec_t;

    vec_t vecs[$];
    int testsRun    = 0;
    int testsFailed = 0;

    task automatic tick();
        @(posedge clk40MHz);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input logic r, input logic e, input int n,
                          input int h, input int v, input logic hs, input logic vs,
                          input logic hb, input logic vb, input logic ls, input logic fs);
        vec_t x;
        x.name = name; x.rst = r; x.en = e; x.cycles = n; x.h = h; x.v = v;
        x.hs = hs; x.vs = vs; x.hb = hb; x.vb = vb; x.ls = ls; x.fs = fs;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t x);
        rstA = x.rst;
        enA  = x.en;
        repeat (x.cycles) tick();
        checkOutput({x.name, ".hcount"},      32'(ifA.hcount), 32'(x.h));
        checkOutput({x.name, ".vcount"},      32'(ifA.vcount), 32'(x.v));
        checkOutput({x.name, ".hsync"},       32'(ifA.hsync),  32'(x.hs));
        checkOutput({x.name, ".vsync"},       32'(ifA.vsync),  32'(x.vs));
        checkOutput({x.name, ".hblnk"},       32'(ifA.hblnk),  32'(x.hb));
        checkOutput({x.name, ".vblnk"},       32'(ifA.vblnk),  32'(x.vb));
        checkOutput({x.name, ".line_start"},  32'(lsA),        32'(x.ls));
        checkOutput({x.name, ".frame_start"}, 32'(fsA),        32'(x.fs));
        checkOutput({x.name, ".rgb"},         32'(ifA.rgb),    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errs, hsPulses, vsCycles, vbCycles, nFs, expH, expV;
        int fsTimes[3];
        logic prevHs;
        logic expHs, expVs, expHb, expVb, expLs, expFs;

        //     name          rst  en  cycles  h     v   hs vs hb vb ls fs
        addVec("reset",      0,   1,  3,      0,    0,  0, 0, 0, 0, 1, 1);
        addVec("first",      1,   1,  1,      1,    0,  0, 0, 0, 0, 0, 0);
        addVec("h799",       1,   1,  798,    799,  0,  0, 0, 0, 0, 0, 0);
        addVec("h800",       1,   1,  1,      800,  0,  0, 0, 1, 0, 0, 0);
        addVec("h839",       1,   1,  39,     839,  0,  0, 0, 1, 0, 0, 0);
        addVec("h840",       1,   1,  1,      840,  0,  1, 0, 1, 0, 0, 0);
        addVec("h967",       1,   1,  127,    967,  0,  1, 0, 1, 0, 0, 0);
        addVec("h968",       1,   1,  1,      968,  0,  0, 0, 1, 0, 0, 0);
        addVec("h1055",      1,   1,  87,     1055, 0,  0, 0, 1, 0, 0, 0);
        addVec("hwrap",      1,   1,  1,      0,    1,  0, 0, 0, 0, 1, 0);
        addVec("line1",      1,   1,  1,      1,    1,  0, 0, 0, 0, 0, 0);
        addVec("to_1055_10", 1,   1,  10558,  1055, 10, 0, 0, 1, 0, 0, 0);
        addVec("hold",       1,   0,  10,     1055, 10, 0, 0, 1, 0, 0, 0);
        addVec("resume",     1,   1,  1,      0,    11, 0, 0, 0, 0, 1, 0);
        addVec("hold_ls",    1,   0,  5,      0,    11, 0, 0, 0, 0, 1, 0);
        addVec("resume2",    1,   1,  1,      1,    11, 0, 0, 0, 0, 0, 0);
        addVec("to_500_12",  1,   1,  1555,   500,  12, 0, 0, 0, 0, 0, 0);
        addVec("mid_reset",  0,   1,  1,      0,    0,  0, 0, 0, 0, 1, 1);
        addVec("release",    1,   1,  1,      1,    0,  0, 0, 0, 0, 0, 0);
        addVec("h10",        1,   1,  9,      10,   0,  0, 0, 0, 0, 0, 0);
        addVec("rst_no_en",  0,   0,  1,      0,    0,  0, 0, 0, 0, 1, 1);
        addVec("idle_rel",   1,   0,  4,      0,    0,  0, 0, 0, 0, 1, 1);
        addVec("start_rel",  1,   1,  1,      1,    0,  0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) applyStimulus(vecs[i]);

        rstB = 1'b0;
        enB  = 1'b1;
        tick();
        tick();
        checkOutput("B.reset.hcount", 32'(ifB.hcount), 32'd0);
        checkOutput("B.reset.vcount", 32'(ifB.vcount), 32'd0);
        checkOutput("B.reset.hsync",  32'(ifB.hsync),  32'd1);
        checkOutput("B.reset.vsync",  32'(ifB.vsync),  32'd1);
        checkOutput("B.reset.fs",     32'(fsB),        32'd1);

        rstB = 1'b1;
        errs = 0; hsPulses = 0; vsCycles = 0; vbCycles = 0; nFs = 0;
        fsTimes = '{default: 0};
        prevHs = 1'b1;
        for (int t = 0; t <= 1400; t++) begin
            if (t > 0) tick();
            expH  = t % 25;
            expV  = (t / 25) % 18;
            expHs = !(expH >= 18 && expH < 22);
            expVs = !(expV >= 13 && expV < 15);
            expHb = (expH >= 16);
            expVb = (expV >= 12);
            expLs = (expH == 0);
            expFs = (expH == 0) && (expV == 0);
            if (32'(ifB.hcount) != expH || 32'(ifB.vcount) != expV || ifB.hsync !== expHs ||
                ifB.vsync !== expVs || ifB.hblnk !== expHb || ifB.vblnk !== expVb ||
                lsB !== expLs || fsB !== expFs)
                errs++;
            if (t < 450) begin
                if (ifB.hsync === 1'b0 && prevHs === 1'b1) hsPulses++;
                if (ifB.vsync === 1'b0) vsCycles++;
                if (ifB.vblnk === 1'b1) vbCycles++;
                prevHs = ifB.hsync;
            end
            if (t > 0 && fsB === 1'b1 && nFs < 3) begin
                fsTimes[nFs] = t;
                nFs++;
            end
            if (t == 449) begin
                checkOutput("B.last.hcount", 32'(ifB.hcount), 32'd24);
                checkOutput("B.last.vcount", 32'(ifB.vcount), 32'd17);
            end
            if (t == 450) begin
                checkOutput("B.wrap.hcount", 32'(ifB.hcount), 32'd0);
                checkOutput("B.wrap.vcount", 32'(ifB.vcount), 32'd0);
                checkOutput("B.wrap.fs",     32'(fsB),        32'd1);
                checkOutput("B.wrap.vblnk",  32'(ifB.vblnk),  32'd0);
            end
        end
        checkOutput("B.decode_errors", 32'(errs),     32'd0);
        checkOutput("B.hsync_pulses",  32'(hsPulses), 32'd18);
        checkOutput("B.vsync_cycles",  32'(vsCycles), 32'd50);
        checkOutput("B.vblnk_cycles",  32'(vbCycles), 32'd150);
        checkOutput("B.fs_count",      32'(nFs),      32'd3);
        checkOutput("B.fs_first",      32'(fsTimes[0]), 32'd450);
        checkOutput("B.fs_period1",    32'(fsTimes[1] - fsTimes[0]), 32'd450);
        checkOutput("B.fs_period2",    32'(fsTimes[2] - fsTimes[1]), 32'd450);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
